// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and state type for the FIFO write-side arbiter
// Purpose: default widths/limits and the arbiter state enum used by fifo_wr_arbiter.
// Ports: none (package).
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 4;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_MAX_BURST  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin priority scan
// Purpose: return the first asserted valid index scanning ptr, ptr+1, ... mod NUM_REQ.
// Ports:
//   valid     in   NUM_REQ  request vector
//   ptr       in   ID_W     index with highest priority this cycle
//   idx       out  ID_W     selected index (0 when nothing is valid)
//   any_valid out  1        at least one request is valid
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               any_valid
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest valid index
    // (lowest offset from ptr) is the last to write idx and therefore wins.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (valid[cand]) begin
                idx       = cand[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
// Purpose: grant the FIFO write port to one of NUM_REQ requesters at a time,
//   bounded bursts of MAX_BURST beats, back-pressured by FIFO full.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   req_valid    per-requester word available
//   req_data     packed requester words, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot (or zero) accept strobe toward requesters
//   full         FIFO full, synchronous to clk
//   winc, wdata  FIFO write strobe and data
//   grant_id     current owner, or last owner while idle
//   busy         a grant is active
//   xfer_cnt     accepted beats since reset, saturating at 255
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = FIFO_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [7:0]                    xfer_cnt
);

    localparam int              ID_W       = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic [7:0]      xfer_cnt_q, xfer_cnt_d;

    logic [ID_W-1:0]       pick_idx;
    logic                  pick_any;
    logic                  in_grant;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [ID_W-1:0]       next_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Datapath toward the FIFO and requesters: purely combinational so a
    // full assertion blocks the write in the same cycle it arrives.
    always_comb begin
        in_grant    = (state_q == GRANT);
        owner_valid = 1'b0;
        owner_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                owner_valid  = req_valid[i];
                owner_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = in_grant & ~full;
            end
        end
        winc    = in_grant & owner_valid & ~full;
        wdata   = winc ? owner_data : '0;
        busy    = in_grant;
        next_id = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // Owner withdrawing valid ends the grant without a beat;
                // a stalled owner (full) keeps the grant indefinitely.
                if (!owner_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_id;
                end else if (winc) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (winc && (xfer_cnt_q != 8'hFF)) begin
            xfer_cnt_d = xfer_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign grant_id = grant_id_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int DW = 4;
    localparam int NR = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              full;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [0:0]        grant_id;
    logic              busy;
    logic [7:0]        xfer_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  log_id[$];
    int  log_cyc[$];
    int  log_dat[$];
    int  cyc = 0;

    // Reference model: who owns the port, beats in this grant, rotation pointer.
    bit  m_gr = 1'b0;
    int  m_own = 0;
    int  m_beats = 0;
    int  m_ptr = 0;
    int  m_cnt = 0;
    int  m_cnt_prev = 0;
    int  m_acc = -1;
    logic [DW-1:0] cur [NR];

    logic [DW-1:0] words [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    wr_t           mon_w;
    logic [NR-1:0] mon_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        int  i;
        bit  found;
        wr_t w;
        m_acc = -1;
        if (!m_gr) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                i = (m_ptr + k) % NR;
                if (!found && req_valid[i]) begin
                    m_own = i;
                    found = 1'b1;
                end
            end
            if (found) begin
                m_gr    = 1'b1;
                m_beats = 0;
            end
        end else if (!req_valid[m_own]) begin
            m_gr  = 1'b0;
            m_ptr = (m_own + 1) % NR;
        end else if (!full) begin
            w.id   = m_own;
            w.data = req_data[m_own*DW +: DW];
            exp_q.push_back(w);
            m_acc = m_own;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_beats++;
            if (m_beats == MB) begin
                m_gr  = 1'b0;
                m_ptr = (m_own + 1) % NR;
            end
        end
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic f);
        @(posedge clk);
        #1;
        cyc++;
        req_valid  = v;
        req_data   = {cur[1], cur[0]};
        full       = f;
        m_cnt_prev = m_cnt;
        model_cycle();
        if (m_acc >= 0) cur[m_acc] = DW'($urandom);
    endtask

    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_winc", winc, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_gid", grant_id, 0);
        req_valid = '0;
        full      = 1'b0;
        m_gr      = 1'b0;
        m_ptr     = 0;
        m_cnt     = 0;
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        log_id.delete();
        log_cyc.delete();
        log_dat.delete();
    endtask

    // Monitor: every cycle, pop the expected write when winc shows up and
    // make sure no predicted write is left behind.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("winc_while_full", winc & full, 0);
            mon_rdy = (busy && !full) ? NR'(1 << grant_id) : '0;
            chk("req_ready", req_ready, mon_rdy);
            if (winc) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("wr_id", grant_id, mon_w.id);
                    chk("wr_data", wdata, mon_w.data);
                    log_id.push_back(int'(grant_id));
                    log_cyc.push_back(cyc);
                    log_dat.push_back(int'(wdata));
                end
            end
            chk("missed_write", exp_q.size(), 0);
        end
    end

    initial begin
        int            c0;
        int            idx;
        logic [NR-1:0] v;
        int            t2_off [5] = '{1, 2, 3, 4, 6};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        full      = 1'b0;
        cur[0]    = '0;
        cur[1]    = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("init_winc", winc, 0);
        chk("init_ready", req_ready, 0);
        chk("init_busy", busy, 0);
        chk("init_xfer", xfer_cnt, 0);
        chk("init_gid", grant_id, 0);
        chk("init_wdata", wdata, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Single requester streaming A..E.
        clear_log();
        c0  = cyc + 1;
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            if (idx < 5) cur[0] = words[idx];
            drive((idx < 5) ? 2'b01 : 2'b00, 1'b0);
            if (m_acc == 0) idx++;
        end
        @(negedge clk);
        #1;
        chk("t2_xfer", xfer_cnt, 5);
        chk("t2_nwr", log_id.size(), 5);
        for (int k = 0; k < 5 && k < log_id.size(); k++) begin
            chk("t2_cycle", log_cyc[k] - c0, t2_off[k]);
            chk("t2_data", log_dat[k], words[k]);
        end

        // Mid-burst reset with both valid, then alternating full-length bursts.
        repeat (7) drive(2'b11, 1'b0);
        reset_mid();
        clear_log();
        c0 = cyc + 1;
        repeat (20) drive(2'b11, 1'b0);
        @(negedge clk);
        #1;
        chk("t3_nwr", log_id.size(), 16);
        for (int k = 0; k < 16 && k < log_id.size(); k++) begin
            chk("t3_owner", log_id[k], (k / 4) % 2);
            chk("t3_cycle", log_cyc[k] - c0, 1 + k + k / 4);
        end

        // Full stall after beat 2.
        reset_mid();
        clear_log();
        c0 = cyc + 1;
        repeat (3) drive(2'b11, 1'b0);
        repeat (3) begin
            drive(2'b11, 1'b1);
            #1;
            chk("t4_stall_busy", busy, 1);
            chk("t4_stall_ready", req_ready, 0);
            chk("t4_stall_winc", winc, 0);
            chk("t4_stall_gid", grant_id, 0);
        end
        repeat (2) drive(2'b11, 1'b0);
        drive(2'b11, 1'b0);
        #1;
        chk("t4_released", busy, 0);
        @(negedge clk);
        #1;
        chk("t4_nwr", log_id.size(), 4);
        for (int k = 0; k < 4 && k < log_id.size(); k++) begin
            chk("t4_owner", log_id[k], 0);
        end
        if (log_cyc.size() == 4) begin
            chk("t4_cyc2", log_cyc[1] - c0, 2);
            chk("t4_cyc3", log_cyc[2] - c0, 6);
            chk("t4_cyc4", log_cyc[3] - c0, 7);
        end

        // Owner drops valid after one beat.
        reset_mid();
        clear_log();
        drive(2'b11, 1'b0);
        drive(2'b11, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b10, 1'b0);
        #1;
        chk("t5_gid", grant_id, 1);
        chk("t5_busy", busy, 1);
        chk("t5_nwr", log_id.size(), 1);

        // Randomized traffic long enough to saturate xfer_cnt.
        v = 2'b10;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!(v[i] && m_acc != i && ($urandom % 16) != 0)) begin
                    v[i] = (($urandom % 4) != 0);
                end
            end
            drive(v, (($urandom % 6) == 0));
            if (n % 50 == 0) begin
                chk("t6_xfer", xfer_cnt, m_cnt_prev);
            end
        end
        @(negedge clk);
        #1;
        chk("t6_saturated", xfer_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
